// File: rtl/relay_timing_link.sv
// relay_timing_link: SSP/single-wire relay engine with round-trip delay measurement and reporting
module relay_timing_link #(
    parameter int                    DIV_LOG2     = 3,
    parameter int                    SYNC_WIDTH   = 4,
    parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN = 4'hA,
    parameter int                    WORD_WIDTH   = 8,
    parameter int                    DELAY_WIDTH  = 32,
    parameter int                    GAP_LOG2     = 16
) (
    input  logic       ck_1356meg,
    input  logic       rst_n,
    input  logic [2:0] mod_type,
    input  logic       ssp_dout,
    output logic       ssp_clk,
    output logic       ssp_frame,
    output logic       ssp_din,
    input  logic       data_in,
    output logic       data_out,
    output logic       overflow,
    output logic [1:0] timing_state
);
    localparam int DW = DIV_LOG2 + 1;
    localparam int FW = $clog2(WORD_WIDTH);
    localparam int IW = $clog2(DELAY_WIDTH);
    localparam int GW = GAP_LOG2 + 1;
    localparam logic [DW-1:0] TICK_AT  = DW'(2 ** DIV_LOG2);
    localparam logic [GW-1:0] GAP_LAST = GW'(2 ** GAP_LOG2 - 1);
    localparam logic [FW-1:0] FRM_LAST = FW'(WORD_WIDTH - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DELAY_WIDTH - 1);
    localparam logic [2:0] M_MASTER = 3'b000;
    localparam logic [2:0] M_SLAVE  = 3'b001;
    localparam logic [2:0] M_DELAY  = 3'b010;

    typedef enum logic [1:0] {IDLE = 2'b00, TIMING = 2'b01, DONE = 2'b10, REPORT = 2'b11} state_t;

    state_t                 state_q, state_d;
    logic [DW-1:0]          div_q, div_d;
    logic                   sclk_q, sclk_d;
    logic                   din_m_q, din_s_q;
    logic [2:0]             mode_q;
    logic [SYNC_WIDTH-1:0]  tx_q, tx_d, rx_q, rx_d, tx_sh, rx_sh;
    logic [FW-1:0]          frm_q, frm_d;
    logic [WORD_WIDTH-1:0]  wsr_q, wsr_d, osr_q, osr_d, ws_sh;
    logic [GW-1:0]          gap_q, gap_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DELAY_WIDTH-1:0] delay_q, delay_d, inc;
    logic                   ovf_q, ovf_d;
    logic                   frame_q, frame_d, sdin_q, sdin_d, dout_q, dout_d;
    logic                   tick, chg;

    assign ssp_clk      = sclk_q;
    assign ssp_frame    = frame_q;
    assign ssp_din      = sdin_q;
    assign data_out     = dout_q;
    assign overflow     = ovf_q;
    assign timing_state = state_q;

    // Next-state logic: divider, mode-change clearing, per-tick mode behaviour and timing FSM
    always_comb begin
        div_d   = div_q + 1'b1;
        sclk_d  = ~div_d[DW-1];
        tick    = div_q == TICK_AT;
        chg     = mod_type != mode_q;
        tx_sh   = {tx_q[SYNC_WIDTH-2:0], ssp_dout};
        rx_sh   = {rx_q[SYNC_WIDTH-2:0], din_s_q};
        ws_sh   = {wsr_q[WORD_WIDTH-2:0], din_s_q};
        inc     = delay_q + 1'b1;
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        frm_d   = frm_q;
        wsr_d   = wsr_q;
        osr_d   = osr_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        delay_d = delay_q;
        ovf_d   = ovf_q;
        frame_d = frame_q;
        sdin_d  = sdin_q;
        dout_d  = dout_q;
        if (state_q == TIMING) begin
            delay_d = inc;
            if (&inc) begin
                ovf_d   = 1'b1;
                state_d = DONE;
            end
        end
        if (chg) begin
            tx_d    = '0;
            rx_d    = '0;
            wsr_d   = '0;
            frm_d   = '0;
            gap_d   = '0;
            frame_d = 1'b0;
            sdin_d  = 1'b0;
            dout_d  = 1'b0;
            if (state_q == REPORT) state_d = DONE;
        end else if (tick) begin
            frame_d = 1'b0;
            sdin_d  = 1'b0;
            dout_d  = 1'b0;
            if (mode_q == M_MASTER) begin
                dout_d  = ssp_dout;
                tx_d    = tx_sh;
                rx_d    = rx_sh;
                frm_d   = (frm_q == FRM_LAST) ? '0 : frm_q + 1'b1;
                frame_d = frm_q == '0;
                if (state_q == IDLE && tx_sh == SYNC_PATTERN) begin
                    state_d = TIMING;
                    delay_d = '0;
                    ovf_d   = 1'b0;
                end else if (state_q == TIMING && rx_sh == SYNC_PATTERN) begin
                    state_d = DONE;
                end
            end
            if (mode_q == M_SLAVE) begin
                dout_d = din_s_q;
                sdin_d = osr_q[WORD_WIDTH-1];
                if (&ws_sh[WORD_WIDTH-1 -: SYNC_WIDTH]) begin
                    frame_d = 1'b1;
                    osr_d   = ws_sh;
                    wsr_d   = '0;
                end else begin
                    wsr_d = ws_sh;
                    osr_d = {osr_q[WORD_WIDTH-2:0], 1'b0};
                end
            end
            if (mode_q == M_DELAY && state_q == DONE) begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) begin
                    state_d = REPORT;
                    idx_d   = '0;
                end
            end
            if (mode_q == M_DELAY && state_q == REPORT) begin
                sdin_d  = delay_q[IDX_LAST - idx_q];
                frame_d = idx_q == '0;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            sclk_q  <= 1'b0;
            din_m_q <= 1'b0;
            din_s_q <= 1'b0;
            mode_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            frm_q   <= '0;
            wsr_q   <= '0;
            osr_q   <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
            delay_q <= '0;
            ovf_q   <= 1'b0;
            frame_q <= 1'b0;
            sdin_q  <= 1'b0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            sclk_q  <= sclk_d;
            din_m_q <= data_in;
            din_s_q <= din_m_q;
            mode_q  <= mod_type;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            frm_q   <= frm_d;
            wsr_q   <= wsr_d;
            osr_q   <= osr_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            delay_q <= delay_d;
            ovf_q   <= ovf_d;
            frame_q <= frame_d;
            sdin_q  <= sdin_d;
            dout_q  <= dout_d;
        end
    end
endmodule
